// File: rtl/alien_depth_sorter_if.sv
// Alien entry type and the sorter's game-side / renderer-side bundle.
// The sorter takes the slave side; game logic and bench take the master side.
package alien_pkg;
    localparam int OBJ_LIMIT = 8;
    localparam int R_W       = 4;

    typedef struct packed {
        logic           _active;
        logic [1:0]     _quadrant;
        logic [1:0]     _type;
        logic [2:0]     _frame_num;
        logic [R_W-1:0] _r;
    } AlienData;
endpackage

interface alien_depth_sorter_if #(
    parameter int N  = alien_pkg::OBJ_LIMIT,
    parameter int CW = $clog2(N+1)
);
    import alien_pkg::*;

    logic          frame_tick;
    AlienData      obj_in  [0:N-1];
    AlienData      obj_out [0:N-1];
    logic [CW-1:0] active_count;
    logic          busy;
    logic          done;
    logic          overrun;

    modport master (
        output frame_tick, obj_in,
        input  obj_out, active_count, busy, done, overrun
    );

    modport slave (
        input  frame_tick, obj_in,
        output obj_out, active_count, busy, done, overrun
    );
endinterface

// File: rtl/alien_depth_sorter.sv
// Per-frame stable depth sort of the alien array (active first, ascending _r),
// odd-even transposition, published atomically during vertical blanking.
module alien_depth_sorter
    import alien_pkg::*;
#(
    parameter int N  = OBJ_LIMIT,
    parameter int CW = $clog2(N+1)
) (
    input  logic                 clk_25MHz,
    input  logic                 rst_n,
    alien_depth_sorter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SORT, PUBLISH} state_t;

    state_t        r_state;
    state_t        w_next;
    AlienData      r_work [0:N-1];
    AlienData      w_pass [0:N-1];
    AlienData      r_out  [0:N-1];
    logic [CW-1:0] r_pass;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_cnt;
    logic          r_done;
    logic          r_overrun;

    // Inactive entries collapse to one key so they never swap among themselves.
    function automatic logic [R_W:0] key(input logic act,
                                         input logic [R_W-1:0] r);
        return act ? {1'b0, r} : {1'b1, {R_W{1'b0}}};
    endfunction

    always_comb begin
        w_pass = r_work;
        for (int i = 0; i < N-1; i++) begin
            if ((i[0] == r_pass[0]) &&
                (key(r_work[i]._active, r_work[i]._r) >
                 key(r_work[i+1]._active, r_work[i+1]._r))) begin
                w_pass[i]   = r_work[i+1];
                w_pass[i+1] = r_work[i];
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt = w_cnt + {{(CW-1){1'b0}}, r_work[i]._active};
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.frame_tick) w_next = SORT;
            SORT:    if (r_pass == CW'(N-1)) w_next = PUBLISH;
            PUBLISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_work    <= '{default: '0};
            r_out     <= '{default: '0};
            r_pass    <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= (r_state == PUBLISH);
            r_overrun <= r_overrun | (bus.frame_tick && (r_state != IDLE));
            unique case (r_state)
                IDLE: begin
                    if (bus.frame_tick) begin
                        r_work <= bus.obj_in;
                        r_pass <= '0;
                    end
                end
                SORT: begin
                    r_work <= w_pass;
                    r_pass <= r_pass + 1'b1;
                end
                PUBLISH: begin
                    r_out   <= r_work;
                    r_count <= w_cnt;
                end
                default: ;
            endcase
        end
    end

    assign bus.obj_out      = r_out;
    assign bus.active_count = r_count;
    assign bus.busy         = (r_state != IDLE);
    assign bus.done         = r_done;
    assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_alien_depth_sorter.sv
// Directed table-driven bench for alien_depth_sorter (N=8),
// plus hand sequences for overrun, back-to-back tick and mid-sort reset.
module tb_alien_depth_sorter;
    import alien_pkg::*;

    localparam int N = 8;

    typedef struct {
        logic [3:0] r   [N];
        logic [7:0] act;
        int         idx [N];
        int         cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [6];
    AlienData exp_snap [N];

    alien_depth_sorter_if #(.N(N)) bus ();

    alien_depth_sorter #(.N(N)) dut (
        .clk_25MHz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic AlienData mk(input int i, input logic a,
                                    input logic [3:0] r);
        AlienData e;
        logic [31:0] iv;
        iv          = i;
        e._active   = a;
        e._quadrant = iv[1:0];
        e._type     = ~iv[1:0];
        e._frame_num = iv[2:0];
        e._r        = r;
        return e;
    endfunction

    // drive obj_in from a vector; upd also records it as the expected snapshot
    task automatic load(input int v, input bit upd);
        for (int i = 0; i < N; i++) begin
            bus.obj_in[i] = mk(i, vecs[v].act[i], vecs[v].r[i]);
            if (upd) exp_snap[i] = mk(i, vecs[v].act[i], vecs[v].r[i]);
        end
    endtask

    task automatic check_out(input int v);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("v%0d_entry%0d", v, k), 32'(bus.obj_out[k]),
                32'(exp_snap[vecs[v].idx[k]]));
        end
        chk($sformatf("v%0d_count", v), 32'(bus.active_count), vecs[v].cnt);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
    endtask

    // returns at the negedge where done is first seen
    task automatic wait_done(input string nm);
        int busy_n;
        int dc;
        busy_n = 0;
        dc = 0;
        for (int c = 1; c <= N + 6 && dc == 0; c++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) dc = c;
        end
        chk({nm, "_done_cycle"}, dc, N + 2);
        chk({nm, "_busy_cycles"}, busy_n, N + 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0].r = '{7, 3, 9, 1, 12, 3, 0, 5};
        vecs[0].act = 8'hFF;
        vecs[0].idx = '{6, 3, 1, 5, 7, 0, 2, 4};
        vecs[0].cnt = 8;

        vecs[1].r = '{15, 2, 8, 4, 1, 6, 3, 0};
        vecs[1].act = 8'b1010_0110;
        vecs[1].idx = '{7, 1, 5, 2, 0, 3, 4, 6};
        vecs[1].cnt = 4;

        vecs[2].r = '{15, 14, 13, 12, 11, 10, 9, 8};
        vecs[2].act = 8'hFF;
        vecs[2].idx = '{7, 6, 5, 4, 3, 2, 1, 0};
        vecs[2].cnt = 8;

        vecs[3].r = '{5, 4, 3, 2, 1, 0, 7, 6};
        vecs[3].act = 8'h00;
        vecs[3].idx = '{0, 1, 2, 3, 4, 5, 6, 7};
        vecs[3].cnt = 0;

        vecs[4].r = '{5, 5, 5, 5, 5, 5, 5, 5};
        vecs[4].act = 8'hFF;
        vecs[4].idx = '{0, 1, 2, 3, 4, 5, 6, 7};
        vecs[4].cnt = 8;

        vecs[5].r = '{1, 2, 3, 4, 5, 6, 7, 9};
        vecs[5].act = 8'h80;
        vecs[5].idx = '{7, 0, 1, 2, 3, 4, 5, 6};
        vecs[5].cnt = 1;

        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        load(0, 1);
        #5;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < N; k++)
            chk($sformatf("idle_entry%0d", k), 32'(bus.obj_out[k]), 0);
        chk("idle_count", 32'(bus.active_count), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_done", 32'(bus.done), 0);
        chk("idle_overrun", 32'(bus.overrun), 0);

        for (int v = 0; v < 6; v++) begin
            load(v, 1);
            pulse_tick();
            wait_done($sformatf("vec%0d", v));
            check_out(v);
            chk($sformatf("vec%0d_overrun", v), 32'(bus.overrun), 0);
        end

        // tick in the cycle done is high is a fresh, legal sort
        load(0, 1);
        pulse_tick();
        wait_done("pre_b2b");
        load(2, 1);
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
        chk("b2b_overrun", 32'(bus.overrun), 0);
        chk("b2b_busy", 32'(bus.busy), 1);
        begin
            int dc;
            dc = 0;
            for (int c = 1; c <= N + 6 && dc == 0; c++) begin
                @(negedge clk);
                if (bus.done) dc = c;
            end
            chk("b2b_done_cycle", dc, N + 2);
        end
        check_out(2);
        chk("b2b_overrun_end", 32'(bus.overrun), 0);

        // overrun: input rewritten and second tick mid-sort are both ignored
        load(0, 1);
        pulse_tick();
        begin
            int dc;
            dc = 0;
            for (int c = 1; c <= N + 6 && dc == 0; c++) begin
                @(negedge clk);
                if (c == 3) load(2, 0);
                bus.frame_tick = (c == 5);
                if (bus.done) dc = c;
            end
            bus.frame_tick = 1'b0;
            chk("ovr_done_cycle", dc, N + 2);
        end
        check_out(0);
        chk("ovr_overrun", 32'(bus.overrun), 1);
        load(2, 1);
        pulse_tick();
        wait_done("ovr_third");
        check_out(2);
        chk("ovr_sticky", 32'(bus.overrun), 1);

        // reset mid-sort
        load(1, 1);
        pulse_tick();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++)
            chk($sformatf("mrst_entry%0d", k), 32'(bus.obj_out[k]), 0);
        chk("mrst_count", 32'(bus.active_count), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_overrun", 32'(bus.overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_tick();
        wait_done("post_rst");
        check_out(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
